// File: rtl/random_pkg.sv
// Shared constants for the random stream generator: default seed and
// maximal-length feedback masks for the supported LFSR widths.
package random_pkg;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Feedback masks for shift-left Fibonacci LFSRs, one bit per tap position.
    localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    // Picks the stock mask for a width. Other widths need an explicit TAPS.
    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] taps;
        case (width)
            8:       taps = TAPS_W8;
            24:      taps = TAPS_W24;
            32:      taps = TAPS_W32;
            default: taps = TAPS_W16;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/random_stream_noise_sync.sv
// Brings the asynchronous noise pin into the clock domain and turns each
// transition into a single-cycle pulse.
module noise_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic noise,
    output logic noise_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Two-flop synchroniser plus one extra stage for the edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= noise;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign noise_edge = r_sync2 ^ r_sync3;

endmodule

// File: rtl/random_stream.sv
// LFSR-based random word source with noise whitening, seed loading and a
// valid/ready output handshake. A word is only offered once OUT_WIDTH
// fresh bits have been shifted in since the previous capture.
module random_stream
    import random_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] TAPS      = default_taps(WIDTH),
    parameter logic [31:0] SEED      = DEFAULT_SEED,
    parameter int          OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 noise,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed,
    output logic [OUT_WIDTH-1:0] rand_data,
    output logic                 rand_valid,
    input  logic                 rand_ready
);

    localparam int               CW       = $clog2(OUT_WIDTH + 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(OUT_WIDTH);
    localparam logic [WIDTH-1:0] W_TAPS   = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] W_SEED   = SEED[WIDTH-1:0];

    logic [WIDTH-1:0]     r_lfsr;
    logic [CW-1:0]        r_cnt;
    logic [OUT_WIDTH-1:0] r_data;
    logic                 r_valid;

    logic                 w_noise_edge;
    logic                 w_fb;
    logic                 w_capture;
    logic [WIDTH-1:0]     w_seed_val;

    noise_sync u_noise_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .noise      (noise),
        .noise_edge (w_noise_edge)
    );

    // Feedback bit, capture decision and sanitised seed.
    always_comb begin
        w_fb       = 1'b0;
        w_capture  = 1'b0;
        w_seed_val = seed;
        // An all-zero register would never leave zero, so inject a one.
        if (r_lfsr == '0) begin
            w_fb = 1'b1;
        end else begin
            w_fb = (^(r_lfsr & W_TAPS)) ^ w_noise_edge;
        end
        w_capture = (r_cnt == CNT_FULL) && (!r_valid || rand_ready);
        if (seed == '0) begin
            w_seed_val = W_SEED;
        end
    end

    // LFSR, fresh-bit counter and output word register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr  <= W_SEED;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (seed_load) begin
            r_lfsr  <= w_seed_val;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (en) begin
                r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
            end
            if (w_capture) begin
                // Word is taken from the register before this edge's shift.
                r_data  <= r_lfsr[OUT_WIDTH-1:0];
                r_valid <= 1'b1;
                r_cnt   <= en ? CW'(1) : '0;
            end else begin
                if (en && (r_cnt != CNT_FULL)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (r_valid && rand_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign rand_data  = r_data;
    assign rand_valid = r_valid;

endmodule
